// File: rtl/aig_stream_evaluator_if.sv
// rtl/aig_stream_evaluator_if.sv - Handshake bundle for the AIG stream evaluator
//
// Purpose: groups the configuration, input-vector, result and status signals
// of aig_stream_evaluator so they can be passed as a single port.
// Signals:
//   cfg_valid/cfg_ready, cfg_op[1:0], cfg_lit0/cfg_lit1[LIT_W], cfg_po_idx : node/PO load
//   in_valid/in_ready, in_pi[NUM_PI]                                      : input vector
//   out_valid/out_ready, out_po[NUM_PO]                                   : result vector
//   busy, err                                                             : status
// Modports: slave = evaluator side, master = driver/checker side.
interface aig_stream_evaluator_if #(
  parameter int NUM_PI  = 4,
  parameter int NUM_PO  = 10,
  parameter int MAX_AND = 64
);
  localparam int LIT_W = $clog2(2 * (1 + NUM_PI + MAX_AND));
  localparam int POI_W = (NUM_PO > 1) ? $clog2(NUM_PO) : 1;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_op;
  logic [LIT_W-1:0]  cfg_lit0;
  logic [LIT_W-1:0]  cfg_lit1;
  logic [POI_W-1:0]  cfg_po_idx;
  logic              in_valid;
  logic              in_ready;
  logic [NUM_PI-1:0] in_pi;
  logic              out_valid;
  logic              out_ready;
  logic [NUM_PO-1:0] out_po;
  logic              busy;
  logic              err;

  modport slave (
    input  cfg_valid, cfg_op, cfg_lit0, cfg_lit1, cfg_po_idx, in_valid, in_pi, out_ready,
    output cfg_ready, in_ready, out_valid, out_po, busy, err
  );

  modport master (
    output cfg_valid, cfg_op, cfg_lit0, cfg_lit1, cfg_po_idx, in_valid, in_pi, out_ready,
    input  cfg_ready, in_ready, out_valid, out_po, busy, err
  );
endinterface

// File: rtl/aig_stream_evaluator.sv
// rtl/aig_stream_evaluator.sv - Programmable and-inverter-graph evaluator, one AND node per cycle
//
// Purpose: holds a run-time loaded AND-node list and PO literals, evaluates
// each accepted input vector node by node and presents the PO values.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (also discards the configuration)
//   bus  : aig_stream_evaluator_if.slave (config, input, output, busy/err)
module aig_stream_evaluator #(
  parameter int NUM_PI  = 4,
  parameter int NUM_PO  = 10,
  parameter int MAX_AND = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  aig_stream_evaluator_if.slave  bus
);
  localparam int NUM_VARS = 1 + NUM_PI + MAX_AND;
  localparam int LIT_W    = $clog2(2 * NUM_VARS);
  localparam int VAR_W    = LIT_W - 1;
  // Value vector spans every encodable var so any literal indexes in range.
  localparam int VAL_N    = 2 ** VAR_W;
  localparam int K_W      = (MAX_AND > 1) ? $clog2(MAX_AND) : 1;
  localparam int N_W      = $clog2(MAX_AND + 1);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESOLVE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [N_W-1:0]     n_and_q;
  logic [K_W-1:0]     k_q;
  logic [LIT_W-1:0]   lit0_mem [MAX_AND];
  logic [LIT_W-1:0]   lit1_mem [MAX_AND];
  logic [LIT_W-1:0]   po_lit_q [NUM_PO];
  logic [VAL_N-1:0]   val_q;
  logic [NUM_PO-1:0]  out_po_q;
  logic               out_valid_q;
  logic               err_q;

  function automatic logic lit_val(input logic [VAL_N-1:0] v, input logic [LIT_W-1:0] lit);
    return v[lit[LIT_W-1:1]] ^ lit[0];
  endfunction

  logic             cfg_fire;
  logic [VAR_W-1:0] known_lim;
  logic             lit0_ok, lit1_ok, add_ok, po_ok;
  logic [VAR_W-1:0] node_var;
  logic             node_val;
  logic             last_node;

  assign cfg_fire  = bus.cfg_valid && bus.cfg_ready;
  // Vars below this bound are constant, PIs or already-loaded nodes; referencing
  // only those keeps the node list topologically ordered.
  assign known_lim = VAR_W'(NUM_PI + 1) + VAR_W'(n_and_q);
  assign lit0_ok   = bus.cfg_lit0[LIT_W-1:1] < known_lim;
  assign lit1_ok   = bus.cfg_lit1[LIT_W-1:1] < known_lim;
  assign add_ok    = lit0_ok && lit1_ok && (int'(n_and_q) < MAX_AND);
  assign po_ok     = lit0_ok && (int'(bus.cfg_po_idx) < NUM_PO);

  assign node_var  = VAR_W'(NUM_PI + 1) + VAR_W'(k_q);
  assign node_val  = lit_val(val_q, lit0_mem[k_q]) & lit_val(val_q, lit1_mem[k_q]);
  assign last_node = (N_W'(k_q) == n_and_q - N_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.in_valid) state_d = (n_and_q != '0) ? S_EVAL : S_RESOLVE;
      S_EVAL:    if (last_node) state_d = S_RESOLVE;
      S_RESOLVE: state_d = S_DONE;
      S_DONE:    if (bus.out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic; an input vector wins over a same-cycle config write.
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.cfg_ready = (state_q == S_IDLE) && !bus.in_valid;
    bus.busy      = (state_q != S_IDLE);
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_po    = out_po_q;
  assign bus.err       = err_q;

  // Fan-in literal RAM; contents are meaningless beyond n_and.
  always_ff @(posedge clk) begin
    if (!rst && cfg_fire && bus.cfg_op == 2'b00 && add_ok) begin
      lit0_mem[n_and_q[K_W-1:0]] <= bus.cfg_lit0;
      lit1_mem[n_and_q[K_W-1:0]] <= bus.cfg_lit1;
    end
  end

  // Configuration registers and evaluation datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      n_and_q     <= '0;
      k_q         <= '0;
      val_q       <= '0;
      out_po_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      for (int j = 0; j < NUM_PO; j++) po_lit_q[j] <= '0;
    end else begin
      if (cfg_fire) begin
        case (bus.cfg_op)
          2'b00: begin
            if (add_ok) n_and_q <= n_and_q + N_W'(1);
            else        err_q   <= 1'b1;
          end
          2'b01: begin
            if (po_ok) begin
              for (int j = 0; j < NUM_PO; j++)
                if (int'(bus.cfg_po_idx) == j) po_lit_q[j] <= bus.cfg_lit0;
            end else begin
              err_q <= 1'b1;
            end
          end
          2'b10: begin
            n_and_q <= '0;
            err_q   <= 1'b0;
            for (int j = 0; j < NUM_PO; j++) po_lit_q[j] <= '0;
          end
          default: err_q <= 1'b1;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            // Var 0 stays constant 0; AND values are cleared for the new vector.
            val_q             <= '0;
            val_q[NUM_PI:1]   <= bus.in_pi;
            k_q               <= '0;
          end
        end
        S_EVAL: begin
          val_q[node_var] <= node_val;
          k_q             <= k_q + K_W'(1);
        end
        S_RESOLVE: begin
          for (int j = 0; j < NUM_PO; j++) out_po_q[j] <= lit_val(val_q, po_lit_q[j]);
          out_valid_q <= 1'b1;
        end
        S_DONE: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aig_stream_evaluator.sv
// tb/tb_aig_stream_evaluator.sv - Self-checking bench for aig_stream_evaluator
module tb_aig_stream_evaluator;
  localparam int NUM_PI  = 4;
  localparam int NUM_PO  = 10;
  localparam int MAX_AND = 64;
  localparam int NVARS   = 1 + NUM_PI + MAX_AND;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aig_stream_evaluator_if #(.NUM_PI(NUM_PI), .NUM_PO(NUM_PO), .MAX_AND(MAX_AND)) bus ();
  aig_stream_evaluator #(.NUM_PI(NUM_PI), .NUM_PO(NUM_PO), .MAX_AND(MAX_AND)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: node list, PO literals, error flag
  int m_n;
  int m_l0 [MAX_AND];
  int m_l1 [MAX_AND];
  int m_po [NUM_PO];
  bit m_err;

  task automatic model_reset();
    m_n = 0; m_err = 0;
    for (int j = 0; j < NUM_PO; j++) m_po[j] = 0;
  endtask

  function automatic logic [NUM_PO-1:0] model_eval(input logic [NUM_PI-1:0] pi);
    int v [NVARS];
    logic [NUM_PO-1:0] r;
    for (int i = 0; i < NVARS; i++) v[i] = 0;
    for (int i = 0; i < NUM_PI; i++) v[i+1] = int'(pi[i]);
    for (int k = 0; k < m_n; k++)
      v[NUM_PI+1+k] = (v[m_l0[k]/2] ^ (m_l0[k]%2)) & (v[m_l1[k]/2] ^ (m_l1[k]%2));
    for (int j = 0; j < NUM_PO; j++) r[j] = 1'((v[m_po[j]/2] ^ (m_po[j]%2)));
    return r;
  endfunction

  // Drive one config write from IDLE and apply the same rule to the model.
  task automatic cfg(input int op, input int l0, input int l1, input int idx);
    int lim;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1; bus.cfg_op = 2'(op);
    bus.cfg_lit0 = 8'(l0); bus.cfg_lit1 = 8'(l1); bus.cfg_po_idx = 4'(idx);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    lim = NUM_PI + 1 + m_n;
    case (op)
      0: if (l0/2 < lim && l1/2 < lim && m_n < MAX_AND) begin
           m_l0[m_n] = l0; m_l1[m_n] = l1; m_n++;
         end else m_err = 1;
      1: if (l0/2 < lim && idx < NUM_PO) m_po[idx] = l0; else m_err = 1;
      2: begin m_n = 0; m_err = 0; for (int j = 0; j < NUM_PO; j++) m_po[j] = 0; end
      default: m_err = 1;
    endcase
  endtask

  // Count edges from the accept edge (=1) until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  // Present one vector with out_ready high; returns latency and outputs.
  task automatic run_vec(input logic [NUM_PI-1:0] pi, output int lat, output logic [NUM_PO-1:0] po);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_pi = pi;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(lat);
    po = bus.out_po;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    total++; if (bus.out_po !== '0) begin bad++; $display("FAIL reset_out_po got=%h exp=0", bus.out_po); end
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%b exp=1", bus.cfg_ready); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_nand();
    int lat; logic [NUM_PO-1:0] po;
    cfg(2, 0, 0, 0);
    cfg(0, 2, 6, 0);
    cfg(1, 11, 0, 2);
    run_vec(4'b0101, lat, po);
    total++; if (po !== 10'b0) begin bad++; $display("FAIL nand_0101 got=%b exp=%b", po, 10'b0); end
    total++; if (lat !== 3) begin bad++; $display("FAIL nand_latency got=%0d exp=3", lat); end
    run_vec(4'b0001, lat, po);
    total++; if (po !== 10'b0000000100) begin bad++; $display("FAIL nand_0001 got=%b exp=%b", po, 10'b100); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL nand_err got=%b exp=0", bus.err); end
  endtask

  task automatic test_const_po();
    int lat; logic [NUM_PO-1:0] po;
    cfg(2, 0, 0, 0);
    cfg(1, 0, 0, 0);
    cfg(1, 1, 0, 1);
    run_vec(4'b1010, lat, po);
    total++; if (po !== 10'b0000000010) begin bad++; $display("FAIL const_po got=%b exp=%b", po, 10'b10); end
    total++; if (lat !== 2) begin bad++; $display("FAIL const_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_err();
    int lat; logic [NUM_PO-1:0] po;
    cfg(2, 0, 0, 0);
    cfg(0, 12, 2, 0);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_undef got=%b exp=1", bus.err); end
    run_vec(4'b1111, lat, po);
    total++; if (lat !== 2) begin bad++; $display("FAIL err_node_dropped latency got=%0d exp=2", lat); end
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", bus.err); end
    cfg(2, 0, 0, 0);
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", bus.err); end
    cfg(3, 0, 0, 0);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_reserved got=%b exp=1", bus.err); end
    cfg(1, 2, 0, 11);
    cfg(2, 0, 0, 0);
  endtask

  task automatic test_capacity();
    int lat; logic [NUM_PO-1:0] po;
    cfg(2, 0, 0, 0);
    for (int k = 0; k < MAX_AND; k++) cfg(0, (k == 0) ? 2 : 2*(NUM_PI+k), 2, 0);
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL cap_full_err got=%b exp=0", bus.err); end
    cfg(0, 2, 2, 0);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL cap_overflow_err got=%b exp=1", bus.err); end
    cfg(1, 2*(NUM_PI+MAX_AND), 0, 0);
    run_vec(4'b1111, lat, po);
    total++; if (po !== 10'b1) begin bad++; $display("FAIL cap_chain_1111 got=%b exp=%b", po, 10'b1); end
    total++; if (lat !== MAX_AND + 2) begin bad++; $display("FAIL cap_latency got=%0d exp=%0d", lat, MAX_AND+2); end
    run_vec(4'b1110, lat, po);
    total++; if (po !== model_eval(4'b1110)) begin bad++; $display("FAIL cap_chain_1110 got=%b exp=%b", po, model_eval(4'b1110)); end
  endtask

  task automatic test_backpressure_reset();
    int lat; logic [NUM_PO-1:0] po, held;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_pi = 4'b1111;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(lat);
    held = bus.out_po;
    total++; if (held !== model_eval(4'b1111)) begin bad++; $display("FAIL bp_value got=%b exp=%b", held, model_eval(4'b1111)); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.out_po !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc%0d po=%b exp=%b valid=%b in_ready=%b exp valid=1 in_ready=0",
                        i, bus.out_po, held, bus.out_valid, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready); end
    // Abort evaluation mid-way through the 64-node chain.
    bus.in_valid = 1'b1; bus.in_pi = 4'b1111;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid_eval valid=%b busy=%b exp 0/0", bus.out_valid, bus.busy); end
    run_vec(4'b1111, lat, po);
    total++; if (lat !== 2 || po !== '0) begin
      bad++; $display("FAIL rst_config_lost lat=%0d po=%b exp lat=2 po=0", lat, po); end
  endtask

  task automatic test_collision();
    int lat; logic [NUM_PO-1:0] po;
    cfg(2, 0, 0, 0);
    cfg(0, 2, 4, 0);
    cfg(1, 10, 0, 5);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_pi = 4'b0011;
    bus.cfg_valid = 1'b1; bus.cfg_op = 2'b00; bus.cfg_lit0 = 8'd2; bus.cfg_lit1 = 8'd2;
    #1;
    total++; if (bus.cfg_ready !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL collide_ready cfg_ready=%b in_ready=%b exp 0/1", bus.cfg_ready, bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.cfg_valid = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL collide_accept busy=%b exp=1", bus.busy); end
    wait_out(lat);
    po = bus.out_po;
    @(posedge clk); #1;
    total++; if (lat !== 3 || po !== model_eval(4'b0011)) begin
      bad++; $display("FAIL collide_result lat=%0d po=%b exp lat=3 po=%b", lat, po, model_eval(4'b0011)); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, n;
    cfg(2, 0, 0, 0);
    cfg(0, 3, 5, 0);
    cfg(0, 10, 9, 0);
    cfg(1, 12, 0, 9);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_pi = 4'b0110;
    n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    t1 = cyc;
    @(posedge clk); #1;
    n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    t2 = cyc;
    bus.in_valid = 1'b0;
    total++; if (t2 - t1 !== m_n + 3) begin bad++; $display("FAIL b2b_period got=%0d exp=%0d", t2-t1, m_n+3); end
    total++; if (bus.out_po !== model_eval(4'b0110)) begin
      bad++; $display("FAIL b2b_value got=%b exp=%b", bus.out_po, model_eval(4'b0110)); end
    n = 0;
    while (bus.busy && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_random();
    int lat, lim, op; logic [NUM_PO-1:0] po, exp_po; logic [NUM_PI-1:0] pi;
    for (int r = 0; r < 6; r++) begin
      cfg(2, 0, 0, 0);
      for (int i = 0; i < 14; i++) begin
        lim = NUM_PI + 1 + m_n;
        op  = ($urandom_range(0, 15) == 0) ? 3 : (($urandom_range(0, 2) == 0) ? 1 : 0);
        cfg(op, $urandom_range(0, 2*lim+1), $urandom_range(0, 2*lim+1), $urandom_range(0, NUM_PO+1));
      end
      total++; if (bus.err !== logic'(m_err)) begin bad++; $display("FAIL rnd_err r%0d got=%b exp=%b", r, bus.err, m_err); end
      for (int v = 0; v < 4; v++) begin
        pi = 4'($urandom);
        exp_po = model_eval(pi);
        run_vec(pi, lat, po);
        total++; if (po !== exp_po || lat !== m_n + 2) begin
          bad++; $display("FAIL rnd_eval r%0d pi=%b po=%b exp=%b lat=%0d exp=%0d", r, pi, po, exp_po, lat, m_n+2); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_op = '0; bus.cfg_lit0 = '0; bus.cfg_lit1 = '0; bus.cfg_po_idx = '0;
    bus.in_valid = 1'b0; bus.in_pi = '0; bus.out_ready = 1'b1;
    test_reset();
    test_nand();
    test_const_po();
    test_err();
    test_capacity();
    test_backpressure_reset();
    test_collision();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aig_stream_evaluator.md
# aig_stream_evaluator

Parametrised, programmable and-inverter-graph evaluator for the GCN_AIG benchmark flow. It replaces fixed per-benchmark combinational netlists: the AND-node list and primary-output literals are loaded at run time, then each primary-input vector is evaluated one AND node per cycle. It sits between the dataset stimulus driver and the output checker, so a single instance can run any benchmark with at most `NUM_PI` inputs, `NUM_PO` outputs and `MAX_AND` nodes.

## Interface
- `NUM_PI`, 4, primary-input count.
- `NUM_PO`, 10, primary-output count.
- `MAX_AND`, 64, AND-node capacity.
- `LIT_W`, clog2(2*(1+NUM_PI+MAX_AND)) = 8, literal width (derived, not overridden).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid` in 1, `cfg_ready` out 1: configuration handshake.
- `cfg_op` in 2: 00 add AND; 01 set PO; 10 clear; 11 reserved.
- `cfg_lit0`, `cfg_lit1` in LIT_W: AND fan-in literals. `cfg_lit0` is also the PO literal.
- `cfg_po_idx` in clog2(NUM_PO): PO index for op 01.
- `in_valid` in 1, `in_ready` out 1, `in_pi` in NUM_PI: input-vector handshake. Bit i is variable i+1.
- `out_valid` out 1, `out_ready` in 1, `out_po` out NUM_PO: result handshake.
- `busy` out 1: state is not IDLE.
- `err` out 1: sticky configuration error.

## Operation
- Literal encoding: lit = 2*var + inv.
  - var 0 is constant 0.
  - vars 1..NUM_PI are the PIs.
  - var NUM_PI+1+k is the k-th AND node.
- Node store: `n_and` (count), fan-in literal RAM of MAX_AND entries, NUM_PO PO-literal registers, and a value bit vector for all vars.
- Config is accepted only in IDLE: `cfg_ready = (state==IDLE) && !in_valid`. The input vector has priority on a same-cycle collision.
- Op 00 is accepted if both fan-in vars are < NUM_PI+1+n_and (strictly topological) and n_and < MAX_AND. The node is stored and n_and increments. Otherwise the node is dropped and err is set.
- Op 01 is accepted if cfg_po_idx < NUM_PO and the literal's var is < NUM_PI+1+n_and. Otherwise dropped and err is set.
- Op 10: n_and←0, all PO literals←0 (constant 0), err←0.
- Op 11: err←1, no other effect.
- State machine:
  - IDLE: on `in_valid && in_ready`, latch in_pi into the value vector and clear the AND values. Go to EVAL if n_and>0, else to RESOLVE.
  - EVAL: node k = AND(val(lit0), val(lit1)), where val = value[lit>>1] ^ lit[0]. Write value[NUM_PI+1+k]. k increments; after k = n_and-1, go to RESOLVE.
  - RESOLVE: out_po[j] ← val(PO literal j); out_valid←1; go to DONE.
  - DONE: hold out_po and out_valid until out_ready, then go to IDLE with out_valid←0.
- `in_ready = (state==IDLE)`.
- Variable values referenced in EVAL are always already final, because of the topological-order check at load.

## Timing
- Reset values: state IDLE, n_and 0, PO literals 0, value vector 0, k 0, out_po 0, out_valid 0, err 0, busy 0.
- `cfg_ready` and `in_ready` are 1 from the first cycle after reset (when in_valid=0).
- Latency: out_valid rises exactly n_and+2 cycles after the accepting in_valid edge. With n_and=0 the latency is 2.
- Throughput: one vector per n_and+3 cycles when out_ready is held high.
- At capacity (n_and=MAX_AND) the AND memory is full. Further op 00 sets err; no overwrite, no wrap.
- out_po is stable while out_valid=1 and out_ready=0.
- rst in any state aborts evaluation in the same edge: all reset values apply and the configuration is lost.
- err remains set across evaluations. It is cleared only by rst or op 10.

## Test plan
- Program the single node var5=AND(lit 2, lit 6) and set PO 2 = lit 11 (NAND x0,x2). Drive in_pi=4'b0101 → out_po[2]=0 with out_valid 3 cycles after accept. Drive in_pi=4'b0001 → out_po[2]=1. All other POs read 0.
- PO literals 0 and 1 with n_and=0 → out_po[0]=0 and out_po[1]=1, out_valid 2 cycles after accept.
- Load node var5 referencing lit 12 (var6, undefined) → err=1, n_and stays 0. Then op 10 → err=0.
- Fill 64 chained nodes (each ANDs the previous node with lit 2), then a 65th → err=1, n_and=64. Evaluate in_pi=4'b1111 with PO=last node → out_po=1 at latency 66.
- Hold out_ready=0 for 5 cycles → out_po is stable and in_ready=0 throughout. Assert rst mid-EVAL → next cycle out_valid=0, busy=0, n_and=0.
- Assert cfg_valid and in_valid in the same IDLE cycle → the vector is accepted and cfg_ready=0 that cycle.
